multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM that sequences the multi-cycle MIPS datapath: instruction fetch, decode, execute, memory access and write-back over several cycles, sharing one ALU and one memory port. Replaces the single-cycle opcode decoder as the control source of the Lab datapath. Handles a wait-state memory handshake and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- instr_op_i  in  6  opcode field from instruction register (IR[31:26])
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_req_o  out  1  memory access requested
- iord_o  out  1  memory address: 0=PC, 1=ALUOut
- mem_read_o / mem_write_o  out  1  memory direction
- ir_write_o  out  1  load IR
- pc_write_o / pc_write_cond_o  out  1  unconditional / zero-qualified PC load
- pc_source_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a_o  out  1  0=PC, 1=reg A
- alu_src_b_o  out  2  00=reg B, 01=4, 10=sext imm, 11=sext imm<<2
- alu_op_o  out  3  010 add, 110 sub, 011 R-type (funct decides), 111 slt
- reg_dst_o, mem_to_reg_o, reg_write_o, link_o  out  1  write-back control; link_o selects $31 / PC
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  out  1  one-cycle pulse on unsupported opcode
- retire_cnt_o  out  CNT_W  retired instruction count

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP.
- FETCH: mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00; ir_write and pc_write asserted only when mem_ready_i=1. Stays in FETCH while mem_ready_i=0; → DECODE when 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=010 (branch target into ALUOut). Next by opcode: 000000/001000/001010 → EXEC; 100011/101011 → MEM_ADDR; 000100 → BRANCH; 000010/000011 → JUMP; any other → FETCH with illegal_o=1 (no-op, not counted as retired).
- EXEC: alu_src_a=1; R-type alu_src_b=00, alu_op=011; addi alu_src_b=10, alu_op=010; slti alu_src_b=10, alu_op=111. → ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1 for R-type else 0, mem_to_reg=0, instr_done. → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_req, mem_read, iord=1; wait on mem_ready_i, then → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done. → FETCH.
- MEM_WR: mem_req, mem_write, iord=1; instr_done asserted in the cycle mem_ready_i=1, then → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=01, instr_done. → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done; jal additionally reg_write=1, link_o=1. → FETCH.
- Opcode held in an internal register captured on FETCH→DECODE, so later states are immune to IR changes.
- Every signal not listed for a state is 0.
- retire_cnt_o increments by 1 on each cycle with instr_done_o=1; wraps 2^CNT_W−1 → 0.

## Timing
- Outputs are functions of state register (plus mem_ready_i gating in FETCH/MEM_WR); no output registers.
- Zero-wait cycle counts: beq 3, j 3, jal 3, R/addi/slti 4, sw 4, lw 5. Each wait cycle on mem_ready_i adds one.
- rst_i high: all outputs forced 0 combinationally same cycle; state ← FETCH, counter ← 0 at edge. Reset mid-instruction abandons it without instr_done or count.
- mem_ready_i ignored in states without mem_req_o.

## Structure
- Shared package mips_ctrl_pkg: opcode constants (R, BEQ, ADDI, SLTI, LW, SW, J, JAL), ALU_op encodings, state enum, alu_src_b/pc_source encodings; reused by datapath and bench.
- Single module; no sub-module required.

## Test plan
- Reset held 2 cycles then released, op=000000, mem_ready_i=1 -> FETCH, EXEC, ALU_WB with reg_dst=1, alu_op=011; retire_cnt_o=1 after cycle 4.
- lw (100011) with mem_ready_i low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total, ir_write only on ready cycle, mem_to_reg=1 in MEM_WB.
- beq (000100) -> 3 cycles, pc_write_cond=1, alu_op=110, pc_source=01 in BRANCH; pc_write=0.
- jal (000011) -> JUMP with pc_write=1, pc_source=10, reg_write=1, link_o=1; j (000010) same with reg_write=0.
- op=111111 -> DECODE→FETCH, illegal_o one pulse, retire_cnt_o unchanged.
- Preload counter near wrap (CNT_W=4, 15 retires then 1 more) -> 0; rst_i asserted in MEM_WR -> no instr_done, outputs 0, FETCH next.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU ops, mux selects, FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr, StExec, StAluWb, StBranch, StJump
  } state_e;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory wait states and a retire counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic [1:0]       pc_source_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             link_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [5:0]       r_op;
  logic [CNT_W-1:0] r_cnt;

  // Opcode is latched with the IR load so later states ignore IR changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StFetch;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      if (instr_done_o) r_cnt <= r_cnt + CntOne;
      unique case (r_state)
        StFetch: begin
          if (mem_ready_i) begin
            r_op    <= instr_op_i;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          case (r_op)
            OP_R, OP_ADDI, OP_SLTI: r_state <= StExec;
            OP_LW, OP_SW:           r_state <= StMemAddr;
            OP_BEQ:                 r_state <= StBranch;
            OP_J, OP_JAL:           r_state <= StJump;
            default:                r_state <= StFetch;
          endcase
        end
        StExec:    r_state <= StAluWb;
        StMemAddr: r_state <= (r_op == OP_LW) ? StMemRd : StMemWr;
        StMemRd:   if (mem_ready_i) r_state <= StMemWb;
        StMemWr:   if (mem_ready_i) r_state <= StFetch;
        default:   r_state <= StFetch;
      endcase
    end
  end

  always_comb begin
    mem_req_o       = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = PCSRC_ALU;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = 3'b000;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    link_o          = 1'b0;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    retire_cnt_o    = rst_i ? '0 : r_cnt;
    if (!rst_i) begin
      unique case (r_state)
        StFetch: begin
          mem_req_o   = 1'b1;
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          alu_op_o    = ALU_ADD;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        StDecode: begin
          alu_src_b_o = SRCB_IMM_SH;
          alu_op_o    = ALU_ADD;
          illegal_o   = !is_legal(r_op);
        end
        StExec: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = (r_op == OP_R) ? SRCB_REG : SRCB_IMM;
          alu_op_o    = (r_op == OP_R) ? ALU_RTYPE : (r_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        StAluWb: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = (r_op == OP_R);
          instr_done_o = 1'b1;
        end
        StMemAddr: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = ALU_ADD;
        end
        StMemRd: begin
          mem_req_o  = 1'b1;
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        StMemWb: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        StMemWr: begin
          mem_req_o    = 1'b1;
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        StBranch: begin
          alu_src_a_o     = 1'b1;
          alu_src_b_o     = SRCB_REG;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
          instr_done_o    = 1'b1;
        end
        StJump: begin
          pc_write_o   = 1'b1;
          pc_source_o  = PCSRC_JUMP;
          instr_done_o = 1'b1;
          reg_write_o  = (r_op == OP_JAL);
          link_o       = (r_op == OP_JAL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: per-instruction expected control sequences checked every cycle, plus literal pins.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] instr_op_i = 6'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, iord_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o;
  logic       pc_write_cond_o, alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o, link_o;
  logic       instr_done_o, illegal_o;
  logic [1:0] pc_source_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] retire_cnt_o;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_write_cond_o(pc_write_cond_o), .pc_source_o(pc_source_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .link_o(link_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  ctl_t act_ctl;
  assign act_ctl = {mem_req_o, iord_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o,
                    pc_write_cond_o, pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                    reg_dst_o, mem_to_reg_o, reg_write_o, link_o, instr_done_o, illegal_o};

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cyc = 0;
  logic       chk_en = 1'b0;
  ctl_t       exp_ctl = '0;
  logic [3:0] exp_cnt = '0;
  logic [3:0] model_cnt = '0;

  // Per-cycle comparison against the expected control word and retire count.
  always @(negedge clk_i) begin
    if (chk_en) begin
      checks++;
      if (act_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl t=%0t act=%h exp=%h", $time, act_ctl, exp_ctl);
      end
      checks++;
      if (retire_cnt_o !== exp_cnt) begin
        failures++;
        $display("FAIL retire_cnt t=%0t act=%0d exp=%0d", $time, retire_cnt_o, exp_cnt);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy, input ctl_t e);
    @(posedge clk_i);
    #1;
    rst_i       = rst;
    instr_op_i  = op;
    mem_ready_i = rdy;
    exp_ctl     = e;
    exp_cnt     = rst ? 4'd0 : model_cnt;
    chk_en      = 1'b1;
    cyc++;
    @(negedge clk_i);
    if (instr_done_o && done_cyc == 0) done_cyc = cyc;
    if (rst) model_cnt = 4'd0;
    else if (e.instr_done) model_cnt = model_cnt + 4'd1;
  endtask

  function automatic ctl_t fetch_word(input logic rdy);
    ctl_t w = '0;
    w.mem_req   = 1'b1;
    w.mem_read  = 1'b1;
    w.alu_src_b = 2'b01;
    w.alu_op    = 3'b010;
    w.ir_write  = rdy;
    w.pc_write  = rdy;
    return w;
  endfunction

  function automatic ctl_t decode_word(input logic [5:0] op);
    ctl_t w = '0;
    w.alu_src_b = 2'b11;
    w.alu_op    = 3'b010;
    w.illegal   = !(op inside {6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011,
                               6'b000100, 6'b000010, 6'b000011});
    return w;
  endfunction

  function automatic ctl_t memaddr_word();
    ctl_t w = '0;
    w.alu_src_a = 1'b1;
    w.alu_src_b = 2'b10;
    w.alu_op    = 3'b010;
    return w;
  endfunction

  // One whole instruction: fw/mw are wait cycles in fetch / data access. The opcode input is
  // scrambled after fetch so only the captured copy may steer the later states.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int exp_cycles, input int exp_start);
    ctl_t       e;
    logic [5:0] junk;
    junk     = ~op;
    cyc      = 0;
    done_cyc = 0;
    for (int i = 0; i <= fw; i++) begin
      step(1'b0, op, (i == fw), fetch_word(i == fw));
      if (i == 0) check("cnt_at_fetch", int'(retire_cnt_o), exp_start);
    end
    e = decode_word(op);
    step(1'b0, junk, 1'b1, e);
    case (op)
      6'b000000, 6'b001000, 6'b001010: begin
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = (op == 6'b000000) ? 2'b00 : 2'b10;
        e.alu_op    = (op == 6'b000000) ? 3'b011 : (op == 6'b001010) ? 3'b111 : 3'b010;
        step(1'b0, junk, 1'b1, e);
        e = '0;
        e.reg_write  = 1'b1;
        e.reg_dst    = (op == 6'b000000);
        e.instr_done = 1'b1;
        step(1'b0, junk, 1'b1, e);
      end
      6'b100011: begin
        step(1'b0, junk, 1'b1, memaddr_word());
        e = '0;
        e.mem_req  = 1'b1;
        e.mem_read = 1'b1;
        e.iord     = 1'b1;
        for (int i = 0; i <= mw; i++) step(1'b0, junk, (i == mw), e);
        e = '0;
        e.reg_write  = 1'b1;
        e.mem_to_reg = 1'b1;
        e.instr_done = 1'b1;
        step(1'b0, junk, 1'b1, e);
      end
      6'b101011: begin
        step(1'b0, junk, 1'b1, memaddr_word());
        e = '0;
        e.mem_req   = 1'b1;
        e.mem_write = 1'b1;
        e.iord      = 1'b1;
        for (int i = 0; i <= mw; i++) begin
          e.instr_done = (i == mw);
          step(1'b0, junk, (i == mw), e);
        end
      end
      6'b000100: begin
        e = '0;
        e.alu_src_a     = 1'b1;
        e.alu_op        = 3'b110;
        e.pc_write_cond = 1'b1;
        e.pc_source     = 2'b01;
        e.instr_done    = 1'b1;
        step(1'b0, junk, 1'b1, e);
      end
      6'b000010, 6'b000011: begin
        e = '0;
        e.pc_write   = 1'b1;
        e.pc_source  = 2'b10;
        e.instr_done = 1'b1;
        e.reg_write  = (op == 6'b000011);
        e.link       = (op == 6'b000011);
        step(1'b0, junk, 1'b1, e);
      end
      default: ;
    endcase
    check($sformatf("cycles_op%02h", op), done_cyc, exp_cycles);
  endtask

  initial begin
    step(1'b1, 6'b000000, 1'b1, '0);
    step(1'b1, 6'b000000, 1'b1, '0);
    run_instr(6'b000000, 0, 0, 4, 0);   // R-type
    run_instr(6'b100011, 2, 3, 10, 1);  // lw with fetch and read waits
    run_instr(6'b000100, 0, 0, 3, 2);   // beq
    run_instr(6'b000011, 0, 0, 3, 3);   // jal
    run_instr(6'b000010, 0, 0, 3, 4);   // j
    run_instr(6'b111111, 0, 0, 0, 5);   // illegal: no done, not counted
    run_instr(6'b001000, 1, 0, 5, 5);   // addi with one fetch wait
    run_instr(6'b001010, 0, 0, 4, 6);   // slti
    run_instr(6'b101011, 0, 2, 6, 7);   // sw with two write waits

    // Reset while MEM_WR is completing: no retire, outputs low, back to FETCH.
    step(1'b0, 6'b101011, 1'b1, fetch_word(1'b1));
    check("cnt_before_rst", int'(retire_cnt_o), 8);
    step(1'b0, 6'b010100, 1'b1, decode_word(6'b101011));
    step(1'b0, 6'b010100, 1'b1, memaddr_word());
    step(1'b1, 6'b010100, 1'b1, '0);
    check("done_in_rst", int'(instr_done_o), 0);
    step(1'b0, 6'b000000, 1'b0, fetch_word(1'b0));
    check("cnt_after_rst", int'(retire_cnt_o), 0);

    for (int i = 0; i < 16; i++) run_instr(6'b000100, 0, 0, 3, i);
    run_instr(6'b000000, 0, 0, 4, 0);   // counter wrapped 15 -> 0

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
